mux_nx1_rr: RTL and testbench

MUX_NX1_RR -- requirements
Module: mux_nx1_rr

---
 rtl/mux_nx1_rr.sv | 187 ++++++++++++++++++
 tb/tb_mux_nx1_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr -- N-to-1 valid/ready multiplexer with a one-entry registered
// output stage. Source selection is either manual (S) or round-robin.
//
// Parameters
//   N  : number of input channels (2..16)
//   W  : data width per channel (>= 1)
//   SW : select/index width, clog2(N), at least 1 (derived)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   I        : packed channel data, channel k at I[k*W +: W]
//   I_valid  : per-channel valid
//   I_ready  : per-channel ready, one-hot at the granted channel or zero
//   S        : manual select (MODE = 0)
//   MODE     : 0 = manual select, 1 = round-robin
//   Y        : registered output data
//   Y_valid  : Y holds data
//   Y_ready  : downstream ready
//   Y_sel    : channel index that produced Y
//   P        : XOR-reduction of Y, registered with Y
//              (only with MUX_NX1_RR_PARITY_EN defined)
//
// Build option
//   MUX_NX1_RR_PARITY_EN : adds the parity output P. Undefined by default.
// ---------------------------------------------------------------------------

// Per-channel request qualification.
//   man_hit_o : channel is valid and is the manually selected one
//   hi_req_o  : channel is valid and sits at or above the round-robin pointer
module mux_nx1_rr_lane #(
  parameter int SW = 2,
  parameter int K  = 0
) (
  input  logic          vld_i,
  input  logic [SW-1:0] sel_i,
  input  logic [SW-1:0] ptr_i,
  output logic          man_hit_o,
  output logic          hi_req_o
);
  assign man_hit_o = vld_i && (32'(sel_i) == K);
  assign hi_req_o  = vld_i && (32'(ptr_i) <= K);
endmodule

module mux_nx1_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   I,
  input  logic [N-1:0]     I_valid,
  output logic [N-1:0]     I_ready,
  input  logic [SW-1:0]    S,
  input  logic             MODE,
  output logic [W-1:0]     Y,
  output logic             Y_valid,
  input  logic             Y_ready,
  output logic [SW-1:0]    Y_sel
`ifdef MUX_NX1_RR_PARITY_EN
  ,
  output logic             P
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        y_q, y_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [SW-1:0]       ptr_q, ptr_d;

  logic [N-1:0][W-1:0] ch;
  logic [N-1:0]        man_hit;
  logic [N-1:0]        hi_req;

  logic                load_en;
  logic                man_ok, rr_ok, grant_ok;
  logic [SW-1:0]       rr_idx, grant;
  logic                xfer;

  assign ch = I;

  // ---- per-channel qualification ------------------------------------------
  for (genvar k = 0; k < N; k++) begin : g_lane
    mux_nx1_rr_lane #(.SW(SW), .K(k)) u_lane (
      .vld_i     (I_valid[k]),
      .sel_i     (S),
      .ptr_i     (ptr_q),
      .man_hit_o (man_hit[k]),
      .hi_req_o  (hi_req[k])
    );
  end

  // ---- grant ---------------------------------------------------------------
  // Round-robin is a two-pass priority search: lowest valid channel at or
  // above ptr wins; if none, the lowest valid channel overall (the wrap).
  // Descending loops leave the lowest matching index as the last write.
  always_comb begin
    rr_ok  = 1'b0;
    rr_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (I_valid[k]) begin
        rr_ok  = 1'b1;
        rr_idx = SW'(k);
      end
    end
    for (int k = N-1; k >= 0; k--) begin
      if (hi_req[k]) rr_idx = SW'(k);
    end
  end

  // Out-of-range S (possible when N is not a power of two) never grants.
  assign man_ok   = (32'(S) < N) && (|man_hit);
  assign grant_ok = MODE ? rr_ok  : man_ok;
  assign grant    = MODE ? rr_idx : S;

  // ---- output-stage FSM: state register ------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // ---- output-stage FSM: next state ----------------------------------------
  // Whenever the stage may load, it becomes FULL on a grant and EMPTY
  // otherwise; a stalled FULL stage keeps its state.
  always_comb begin
    state_d = state_q;
    if (load_en) state_d = grant_ok ? FULL : EMPTY;
  end

  // ---- output-stage FSM: outputs -------------------------------------------
  // I_ready is held low during reset; without the gate, load_en would be
  // high there (Y_valid = 0) and a grant could show through.
  always_comb begin
    Y_valid = (state_q == FULL);
    load_en = !Y_valid || Y_ready;
    xfer    = rst_n && load_en && grant_ok;
    I_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (xfer && (grant == SW'(k))) I_ready[k] = 1'b1;
    end
  end

  // ---- data path and round-robin pointer -----------------------------------
  // Y and Y_sel only change on a transfer; the pointer only advances on a
  // round-robin transfer, so manual traffic and idle cycles leave it alone.
  always_comb begin
    y_d   = y_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (xfer) begin
      y_d   = ch[grant];
      sel_d = grant;
      if (MODE) ptr_d = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end

  assign Y     = y_q;
  assign Y_sel = sel_q;

`ifdef MUX_NX1_RR_PARITY_EN
  logic p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    p_q <= 1'b0;
    else if (xfer) p_q <= ^ch[grant];
  end

  assign P = p_q;
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
module tb_mux_nx1_rr;

  logic              clk, rst_n;
  logic [3:0][7:0]   din;
  logic [3:0]        i_valid, i_ready;
  logic [1:0]        s, y_sel;
  logic              mode, y_valid, y_ready;
  logic [7:0]        y;

  logic [2:0][7:0]   din3;
  logic [2:0]        iv3, ir3;
  logic [1:0]        s3, ys3;
  logic              mode3, yv3, yr3;
  logic [7:0]        y3;

`ifdef MUX_NX1_RR_PARITY_EN
  logic p, p3;
`endif

  mux_nx1_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .I(din), .I_valid(i_valid), .I_ready(i_ready),
    .S(s), .MODE(mode), .Y(y), .Y_valid(y_valid), .Y_ready(y_ready),
    .Y_sel(y_sel)
`ifdef MUX_NX1_RR_PARITY_EN
    , .P(p)
`endif
  );

  mux_nx1_rr #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .I(din3), .I_valid(iv3), .I_ready(ir3),
    .S(s3), .MODE(mode3), .Y(y3), .Y_valid(yv3), .Y_ready(yr3),
    .Y_sel(ys3)
`ifdef MUX_NX1_RR_PARITY_EN
    , .P(p3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference model state
  bit         m_yv;
  int         m_ptr;
  logic [7:0] m_y;
  logic [1:0] m_sel;
  logic [9:0] exp_q[$];

  function automatic int mgrant(input bit md, input int sel, input logic [3:0] v, input int p);
    if (!md) return v[sel] ? sel : -1;
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_yv = 0; m_ptr = 0; m_y = 8'h00; m_sel = 2'd0;
    exp_q.delete();
  endtask

  // One clock: check I_ready before the edge, predict, check outputs after.
  task automatic cyc();
    int         g;
    bit         le, xf;
    logic [3:0] er;
    logic [9:0] e;
    @(negedge clk);
    le = !m_yv || y_ready;
    g  = mgrant(mode, int'(s), i_valid, m_ptr);
    xf = le && (g >= 0);
    er = 4'b0000;
    if (xf) er[g] = 1'b1;
    chk("i_ready", 32'(i_ready), 32'(er));
    if (xf) begin
      exp_q.push_back({g[1:0], din[g]});
      if (mode) m_ptr = (g + 1) % 4;
    end
    @(posedge clk); #1;
    if (xf) begin
      e = exp_q.pop_front();
      m_yv = 1; m_y = e[7:0]; m_sel = e[9:8];
    end else if (le) begin
      m_yv = 0;
    end
    chk("y_valid", 32'(y_valid), 32'(m_yv));
    chk("y",       32'(y),       32'(m_y));
    chk("y_sel",   32'(y_sel),   32'(m_sel));
`ifdef MUX_NX1_RR_PARITY_EN
    chk("parity",  32'(p),       32'(^m_y));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0; i_valid = 4'hF; s = 2'd0; mode = 1'b1; y_ready = 1'b1;
    din3 = '0; iv3 = 3'b000; s3 = 2'd0; mode3 = 1'b0; yr3 = 1'b1;
    model_reset();

    // Reset state, with requests pending to prove I_ready is held low
    #2;
    chk("rst_y",       32'(y),       32'h0);
    chk("rst_y_valid", 32'(y_valid), 32'h0);
    chk("rst_y_sel",   32'(y_sel),   32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Manual stream: channel 2 = A5 every cycle
    mode = 1'b0; s = 2'd2; i_valid = 4'b0100; din[2] = 8'hA5; y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("man_y",     32'(y),     32'hA5);
      chk("man_y_sel", 32'(y_sel), 32'd2);
    end

    // Round-robin fairness: all valid, ptr still 0 after manual traffic
    mode = 1'b1; i_valid = 4'b1111;
    din[0] = 8'h10; din[1] = 8'h11; din[2] = 8'h12; din[3] = 8'h13;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_seq", 32'(y_sel), 32'(i % 4));
    end

    // Skip and wrap: get ptr to 3 via grant 2, then 0101 -> 0, 2, 0
    i_valid = 4'b0100; cyc();
    chk("rr_ptr3", 32'(y_sel), 32'd2);
    i_valid = 4'b0101;
    cyc(); chk("rr_wrap0", 32'(y_sel), 32'd0);
    cyc(); chk("rr_skip2", 32'(y_sel), 32'd2);
    cyc(); chk("rr_wrap0b", 32'(y_sel), 32'd0);

    // Backpressure: hold 3C while inputs churn
    mode = 1'b0; s = 2'd0; i_valid = 4'b0001; din[0] = 8'h3C; y_ready = 1'b1;
    cyc();
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 4'($urandom_range(0, 15)); s = 2'($urandom_range(0, 3));
      din[s] = 8'($urandom);
      cyc();
      chk("bp_y",  32'(y),       32'h3C);
      chk("bp_yv", 32'(y_valid), 32'd1);
    end
    y_ready = 1'b1; s = 2'd1; i_valid = 4'b0010; din[1] = 8'h77;
    cyc();
    chk("bp_release", 32'(y), 32'h77);

    // Randomised mix: mode flips, stalls, idles, simultaneous drain/load
    for (int i = 0; i < 300; i++) begin
      mode = 1'($urandom); s = 2'($urandom); i_valid = 4'($urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
      cyc();
    end

    // Out-of-range select on a 3-channel instance
    mode3 = 1'b0; s3 = 2'd1; iv3 = 3'b111; din3[1] = 8'h5A; yr3 = 1'b1;
    @(posedge clk); #1;
    chk("n3_load_yv",  32'(yv3), 32'd1);
    chk("n3_load_sel", 32'(ys3), 32'd1);
    s3 = 2'd3;
    @(negedge clk);
    chk("n3_bad_sel_ir", 32'(ir3), 32'd0);
    @(posedge clk); #1;
    chk("n3_drain_yv", 32'(yv3), 32'd0);
    chk("n3_hold_y",   32'(y3),  32'h5A);

    // Mid-operation reset while FULL and stalled
    mode = 1'b0; s = 2'd3; i_valid = 4'b1000; din[3] = 8'hC3; y_ready = 1'b1;
    cyc();
    y_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_y",       32'(y),       32'h0);
    chk("mrst_y_valid", 32'(y_valid), 32'h0);
    chk("mrst_y_sel",   32'(y_sel),   32'h0);
    chk("mrst_i_ready", 32'(i_ready), 32'h0);
`ifdef MUX_NX1_RR_PARITY_EN
    chk("mrst_p", 32'(p), 32'h0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode = 1'b1; i_valid = 4'b1111; y_ready = 1'b1; din[0] = 8'hE0;
    cyc();
    chk("mrst_first_sel", 32'(y_sel), 32'd0);
    chk("mrst_first_y",   32'(y),     32'hE0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
